// File: rtl/rv32_pkg.sv
// ============================================================================
// Module : rv32_pkg
// Brief  : Shared RV32 encodings, datapath select codes and control states.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32_pkg;

    localparam logic [6:0] C_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] C_OP_IMM    = 7'b0010011;
    localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OP_STORE  = 7'b0100011;
    localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] C_OP_LUI    = 7'b0110111;
    localparam logic [6:0] C_OP_JAL    = 7'b1101111;

    localparam logic [2:0] C_ALU_ADD  = 3'b000;
    localparam logic [2:0] C_ALU_SUB  = 3'b001;
    localparam logic [2:0] C_ALU_PASS = 3'b010;

    localparam logic [1:0] C_SRC_B_RS2  = 2'b00;
    localparam logic [1:0] C_SRC_B_FOUR = 2'b01;
    localparam logic [1:0] C_SRC_B_IMM  = 2'b10;

    localparam logic [1:0] C_WB_ALUOUT = 2'b00;
    localparam logic [1:0] C_WB_MEM    = 2'b01;
    localparam logic [1:0] C_WB_PC     = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CLS_RTYPE = 3'd0,
        CLS_ADDI  = 3'd1,
        CLS_LW    = 3'd2,
        CLS_SW    = 3'd3,
        CLS_BEQ   = 3'd4,
        CLS_LUI   = 3'd5,
        CLS_JAL   = 3'd6,
        CLS_NONE  = 3'd7
    } instr_class_t;

endpackage

`default_nettype wire

// File: rtl/rv32_decode.sv
// ============================================================================
// Module : rv32_decode
// Brief  : Combinational classifier mapping an instruction word to its class.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32_decode
    import rv32_pkg::*;
(
    input  logic [31:0]  i_instr,
    output instr_class_t o_class,
    output logic         o_is_sub,
    output logic         o_illegal
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_unused;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_funct7 = i_instr[31:25];
    // Register and immediate fields do not affect classification.
    assign w_unused = ^{i_instr[24:15], i_instr[11:7]};

    always_comb begin
        o_class = CLS_NONE;
        case (w_opcode)
            C_OP_RTYPE: begin
                if (w_funct3 == 3'b000 &&
                    (w_funct7 == 7'b0000000 || w_funct7 == 7'b0100000))
                    o_class = CLS_RTYPE;
            end
            C_OP_IMM: begin
                if (w_funct3 == 3'b000)
                    o_class = CLS_ADDI;
            end
            C_OP_LOAD: begin
                if (w_funct3 == 3'b010)
                    o_class = CLS_LW;
            end
            C_OP_STORE: begin
                if (w_funct3 == 3'b010)
                    o_class = CLS_SW;
            end
            C_OP_BRANCH: begin
                if (w_funct3 == 3'b000)
                    o_class = CLS_BEQ;
            end
            C_OP_LUI: o_class = CLS_LUI;
            C_OP_JAL: o_class = CLS_JAL;
            default:  o_class = CLS_NONE;
        endcase
    end

    assign o_is_sub  = (w_funct7 == 7'b0100000);
    assign o_illegal = (o_class == CLS_NONE);

endmodule

`default_nettype wire

// File: rtl/mc_control_unit.sv
// ============================================================================
// Module : mc_control_unit
// Brief  : Multi-cycle RV32 sequencer driving datapath selects and enables.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_control_unit
    import rv32_pkg::*;
#(
    parameter int RESET_PC_HOLD = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_read,
    output logic        mem_write,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        oldpc_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_sel,
    output logic        aluout_write,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        retire,
    output logic        illegal
);

    localparam logic [3:0] C_HOLD = 4'(RESET_PC_HOLD);

    state_t       r_state;
    state_t       w_next;
    logic [3:0]   r_hold_cnt;
    instr_class_t w_cls;
    logic         w_is_sub;
    logic         w_illegal;

    rv32_decode u_decode (
        .i_instr   (instr),
        .o_class   (w_cls),
        .o_is_sub  (w_is_sub),
        .o_illegal (w_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && r_hold_cnt != C_HOLD)
                r_hold_cnt <= r_hold_cnt + 4'd1;
        end
    end

    always_comb begin
        w_next       = r_state;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        iord         = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        oldpc_write  = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = C_SRC_B_RS2;
        alu_sel      = C_ALU_ADD;
        aluout_write = 1'b0;
        reg_write    = 1'b0;
        wb_sel       = C_WB_ALUOUT;
        retire       = 1'b0;
        illegal      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (r_hold_cnt == C_HOLD)
                    w_next = ST_FETCH;
            end

            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = C_SRC_B_FOUR;
                if (mem_ready) begin
                    ir_write    = 1'b1;
                    oldpc_write = 1'b1;
                    pc_write    = 1'b1;
                    w_next      = ST_DECODE;
                end
            end

            // Branch/jump target is precomputed from oldpc for every class.
            ST_DECODE: begin
                alu_src_b    = C_SRC_B_IMM;
                aluout_write = 1'b1;
                w_next       = w_illegal ? ST_TRAP : ST_EXEC;
            end

            ST_EXEC: begin
                case (w_cls)
                    CLS_RTYPE: begin
                        alu_src_a    = 1'b1;
                        alu_sel      = w_is_sub ? C_ALU_SUB : C_ALU_ADD;
                        aluout_write = 1'b1;
                        w_next       = ST_WB;
                    end
                    CLS_ADDI, CLS_LW, CLS_SW: begin
                        alu_src_a    = 1'b1;
                        alu_src_b    = C_SRC_B_IMM;
                        aluout_write = 1'b1;
                        w_next       = (w_cls == CLS_ADDI) ? ST_WB : ST_MEM;
                    end
                    CLS_LUI: begin
                        alu_src_b    = C_SRC_B_IMM;
                        alu_sel      = C_ALU_PASS;
                        aluout_write = 1'b1;
                        w_next       = ST_WB;
                    end
                    CLS_BEQ: begin
                        alu_src_a = 1'b1;
                        alu_sel   = C_ALU_SUB;
                        pc_write  = zero;
                        pc_src    = 1'b1;
                        retire    = 1'b1;
                        w_next    = ST_FETCH;
                    end
                    CLS_JAL: begin
                        pc_write  = 1'b1;
                        pc_src    = 1'b1;
                        reg_write = 1'b1;
                        wb_sel    = C_WB_PC;
                        retire    = 1'b1;
                        w_next    = ST_FETCH;
                    end
                    default: w_next = ST_TRAP;
                endcase
            end

            ST_MEM: begin
                iord      = 1'b1;
                mem_read  = (w_cls == CLS_LW);
                mem_write = (w_cls == CLS_SW);
                if (w_cls != CLS_LW && w_cls != CLS_SW) begin
                    w_next = ST_TRAP;
                end else if (mem_ready) begin
                    retire = (w_cls == CLS_SW);
                    w_next = (w_cls == CLS_SW) ? ST_FETCH : ST_WB;
                end
            end

            ST_WB: begin
                reg_write = 1'b1;
                wb_sel    = (w_cls == CLS_LW) ? C_WB_MEM : C_WB_ALUOUT;
                retire    = 1'b1;
                w_next    = ST_FETCH;
            end

            ST_TRAP: illegal = 1'b1;

            default: w_next = ST_IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_mc_control_unit.sv
// ============================================================================
// Module : tb_mc_control_unit
// Brief  : Self-checking bench for mc_control_unit against a per-instruction
//          cycle-script model built from the instruction-class rules.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_control_unit;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       oldpc_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_sel;
        logic       aluout_write;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       retire;
        logic       illegal;
    } outs_t;

    typedef struct {
        outs_t       val;
        outs_t       care;
        logic        rdy;
        logic [31:0] ins;
        logic        zr;
        string       tag;
    } exp_t;

    localparam int K_R = 0, K_ADDI = 1, K_LW = 2, K_SW = 3;
    localparam int K_BEQ = 4, K_LUI = 5, K_JAL = 6, K_ILL = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        mem_read, mem_write, iord, ir_write, pc_write, pc_src;
    logic        oldpc_write, alu_src_a, aluout_write, reg_write, retire, illegal;
    logic [1:0]  alu_src_b, wb_sel;
    logic [2:0]  alu_sel;
    outs_t       obs;

    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        exp_q[$];
    logic [31:0] cur_ir;

    always #5 clk = ~clk;

    mc_control_unit #(.RESET_PC_HOLD(3)) dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .oldpc_write(oldpc_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_sel(alu_sel),
        .aluout_write(aluout_write), .reg_write(reg_write), .wb_sel(wb_sel),
        .retire(retire), .illegal(illegal)
    );

    assign obs = {mem_read, mem_write, iord, ir_write, pc_write, pc_src, oldpc_write,
                  alu_src_a, alu_src_b, alu_sel, aluout_write, reg_write, wb_sel,
                  retire, illegal};

    // ---------------- reference model ----------------
    function automatic int cls_of(input logic [31:0] w);
        logic [2:0] f3 = w[14:12];
        logic [6:0] f7 = w[31:25];
        case (w[6:0])
            7'b0110011: return (f3 == 3'd0 && (f7 == 7'h00 || f7 == 7'h20)) ? K_R : K_ILL;
            7'b0010011: return (f3 == 3'd0) ? K_ADDI : K_ILL;
            7'b0000011: return (f3 == 3'd2) ? K_LW : K_ILL;
            7'b0100011: return (f3 == 3'd2) ? K_SW : K_ILL;
            7'b1100011: return (f3 == 3'd0) ? K_BEQ : K_ILL;
            7'b0110111: return K_LUI;
            7'b1101111: return K_JAL;
            default:    return K_ILL;
        endcase
    endfunction

    function automatic int base_cycles(input int k);
        if (k == K_BEQ || k == K_JAL) return 3;
        if (k == K_LW) return 5;
        return 4;
    endfunction

    function automatic logic [31:0] make_instr(input int k);
        logic [4:0]  rd  = 5'($urandom_range(0, 31));
        logic [4:0]  rs1 = 5'($urandom_range(0, 31));
        logic [4:0]  rs2 = 5'($urandom_range(0, 31));
        logic [11:0] imm = 12'($urandom);
        logic [19:0] up  = 20'($urandom);
        case (k)
            K_R:    return {($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, rs2, rs1, 3'd0, rd, 7'b0110011};
            K_ADDI: return {imm, rs1, 3'd0, rd, 7'b0010011};
            K_LW:   return {imm, rs1, 3'd2, rd, 7'b0000011};
            K_SW:   return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'b0100011};
            K_BEQ:  return {imm[11:5], rs2, rs1, 3'd0, imm[4:0], 7'b1100011};
            K_LUI:  return {up, rd, 7'b0110111};
            default: return {up, rd, 7'b1101111};
        endcase
    endfunction

    function automatic outs_t care_strobes();
        outs_t c = '0;
        c.mem_read = 1; c.mem_write = 1; c.ir_write = 1; c.pc_write = 1;
        c.oldpc_write = 1; c.aluout_write = 1; c.reg_write = 1;
        c.retire = 1; c.illegal = 1;
        return c;
    endfunction

    function automatic outs_t care_alu(input outs_t c0);
        outs_t c = c0;
        c.alu_src_a = 1; c.alu_src_b = '1; c.alu_sel = '1;
        return c;
    endfunction

    function automatic logic rnd_rdy(input bit tie);
        return tie ? 1'b1 : 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input outs_t v, input outs_t c, input logic rdy,
                        input logic [31:0] ins, input logic zr, input string tag);
        exp_t e;
        e.val = v; e.care = c; e.rdy = rdy; e.ins = ins; e.zr = zr; e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Script of expected cycles for one instruction, from fetch to retire.
    task automatic build_instr(input logic [31:0] ins, input logic zr,
                               input int fw, input int mw, input bit tie);
        outs_t v, c;
        int k = cls_of(ins);
        for (int i = 0; i < fw; i++) begin
            v = '0; v.mem_read = 1;
            c = care_strobes(); c.iord = 1;
            push(v, c, 1'b0, cur_ir, zr, "fetch_wait");
        end
        v = '0; v.mem_read = 1; v.ir_write = 1; v.oldpc_write = 1; v.pc_write = 1;
        v.alu_src_b = 2'b01;
        c = care_alu(care_strobes()); c.iord = 1; c.pc_src = 1;
        push(v, c, 1'b1, cur_ir, zr, "fetch_ready");
        cur_ir = ins;
        v = '0; v.aluout_write = 1; v.alu_src_b = 2'b10;
        c = care_alu(care_strobes());
        push(v, c, rnd_rdy(tie), ins, zr, "decode");
        if (k == K_ILL) return;
        v = '0; c = care_alu(care_strobes());
        case (k)
            K_R: begin
                v.aluout_write = 1; v.alu_src_a = 1;
                v.alu_sel = (ins[31:25] == 7'h20) ? 3'b001 : 3'b000;
            end
            K_ADDI, K_LW, K_SW: begin
                v.aluout_write = 1; v.alu_src_a = 1; v.alu_src_b = 2'b10;
            end
            K_LUI: begin
                v.aluout_write = 1; v.alu_src_b = 2'b10; v.alu_sel = 3'b010;
                c.alu_src_a = 0;
            end
            K_BEQ: begin
                v.alu_src_a = 1; v.alu_sel = 3'b001; v.pc_write = zr; v.pc_src = 1;
                v.retire = 1; c.pc_src = 1;
            end
            default: begin
                c = care_strobes(); c.pc_src = 1; c.wb_sel = '1;
                v.pc_write = 1; v.pc_src = 1; v.reg_write = 1; v.wb_sel = 2'b10; v.retire = 1;
            end
        endcase
        push(v, c, rnd_rdy(tie), ins, zr, "exec");
        if (k == K_LW || k == K_SW) begin
            for (int i = 0; i <= mw; i++) begin
                v = '0; v.iord = 1;
                v.mem_read = (k == K_LW); v.mem_write = (k == K_SW);
                v.retire = (i == mw && k == K_SW);
                c = care_strobes(); c.iord = 1;
                push(v, c, (i == mw), ins, zr, (i == mw) ? "mem_ready" : "mem_wait");
            end
        end
        if (k != K_SW && k != K_BEQ && k != K_JAL) begin
            v = '0; v.reg_write = 1; v.retire = 1;
            v.wb_sel = (k == K_LW) ? 2'b01 : 2'b00;
            c = care_strobes(); c.wb_sel = '1;
            push(v, c, rnd_rdy(tie), ins, zr, "wb");
        end
    endtask

    // ---------------- stimulus plumbing ----------------
    task automatic drive(input exp_t e);
        instr = e.ins; mem_ready = e.rdy; zero = e.zr;
        @(negedge clk);
    endtask

    // Leaves the bench just after the edge that enters FETCH (hold = 3).
    task automatic reset_dut();
        rst = 1'b1; mem_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        cur_ir = instr;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int first = -1;
        instr = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (obs !== '0) begin
                n_bad++; $display("FAIL reset_hold: got %05h want 00000", obs);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        for (int i = 0; i < 12 && first < 0; i++) begin
            @(negedge clk);
            if (mem_read === 1'b1) first = i;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (first != 4) begin
            n_bad++; $display("FAIL reset_first_fetch: got cycle %0d want 4", first);
        end
    endtask

    task automatic test_add();
        int idx = 0, ret_at = -1;
        reset_dut();
        build_instr(32'h002081B3, 1'b0, 0, 0, 1'b1);
        while (exp_q.size() > 0) begin
            exp_t e = exp_q.pop_front();
            idx++;
            drive(e);
            n_cmp++;
            if (((obs ^ e.val) & e.care) !== '0) begin
                n_bad++; $display("FAIL add_%s: got %05h want %05h care %05h", e.tag, obs, e.val, e.care);
            end
            if (retire === 1'b1 && ret_at < 0) ret_at = idx;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (ret_at != 4) begin
            n_bad++; $display("FAIL add_retire_cycle: got %0d want 4", ret_at);
        end
    endtask

    task automatic test_lw_wait();
        int idx = 0, ret_at = -1, held = 0;
        reset_dut();
        build_instr(32'h0000A183, 1'b0, 0, 2, 1'b1);
        while (exp_q.size() > 0) begin
            exp_t e = exp_q.pop_front();
            idx++;
            drive(e);
            n_cmp++;
            if (((obs ^ e.val) & e.care) !== '0) begin
                n_bad++; $display("FAIL lw_%s: got %05h want %05h care %05h", e.tag, obs, e.val, e.care);
            end
            if (mem_read === 1'b1 && iord === 1'b1) held++;
            if (retire === 1'b1 && ret_at < 0) ret_at = idx;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (ret_at != 7 || held != 3) begin
            n_bad++; $display("FAIL lw_timing: got retire %0d held %0d want 7 3", ret_at, held);
        end
    endtask

    task automatic test_beq();
        for (int z = 1; z >= 0; z--) begin
            int idx = 0, ret_at = -1;
            reset_dut();
            build_instr(32'h00208063, 1'(z), 0, 0, 1'b0);
            while (exp_q.size() > 0) begin
                exp_t e = exp_q.pop_front();
                idx++;
                drive(e);
                n_cmp++;
                if (((obs ^ e.val) & e.care) !== '0) begin
                    n_bad++; $display("FAIL beq_z%0d_%s: got %05h want %05h care %05h", z, e.tag, obs, e.val, e.care);
                end
                if (retire === 1'b1 && ret_at < 0) ret_at = idx;
                @(posedge clk); #1;
            end
            n_cmp++;
            if (ret_at != 3) begin
                n_bad++; $display("FAIL beq_z%0d_retire_cycle: got %0d want 3", z, ret_at);
            end
        end
    endtask

    task automatic test_jal();
        reset_dut();
        build_instr(32'h008000EF, 1'b0, 0, 0, 1'b0);
        while (exp_q.size() > 0) begin
            exp_t e = exp_q.pop_front();
            drive(e);
            n_cmp++;
            if (((obs ^ e.val) & e.care) !== '0) begin
                n_bad++; $display("FAIL jal_%s: got %05h want %05h care %05h", e.tag, obs, e.val, e.care);
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (mem_read !== 1'b1 || iord !== 1'b0 || ir_write !== 1'b0) begin
            n_bad++; $display("FAIL jal_next_fetch: got rd %b iord %b irw %b want 1 0 0", mem_read, iord, ir_write);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_illegal();
        for (int t = 0; t < 4; t++) begin
            logic [31:0] w = 32'hFFFF_FFFF;
            outs_t v, c;
            if (t > 0) begin
                w = $urandom;
                while (cls_of(w) != K_ILL) w = $urandom;
            end
            reset_dut();
            build_instr(w, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 0, 1'b0);
            v = '0; v.illegal = 1; c = '1;
            for (int i = 0; i < 20; i++) push(v, c, 1'($urandom_range(0, 1)), w, 1'b0, "trap");
            while (exp_q.size() > 0) begin
                exp_t e = exp_q.pop_front();
                drive(e);
                n_cmp++;
                if (((obs ^ e.val) & e.care) !== '0) begin
                    n_bad++; $display("FAIL ill_%08h_%s: got %05h want %05h care %05h", w, e.tag, obs, e.val, e.care);
                end
                @(posedge clk); #1;
            end
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            v = '0; c = '1;
            for (int i = 0; i < 4; i++) push(v, c, 1'b1, w, 1'b0, "post_trap_idle");
            v.mem_read = 1; c = care_strobes(); c.iord = 1;
            push(v, c, 1'b0, w, 1'b0, "post_trap_fetch");
            while (exp_q.size() > 0) begin
                exp_t e = exp_q.pop_front();
                drive(e);
                n_cmp++;
                if (((obs ^ e.val) & e.care) !== '0) begin
                    n_bad++; $display("FAIL ill_%08h_%s: got %05h want %05h care %05h", w, e.tag, obs, e.val, e.care);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset_mid_sw();
        int first = -1;
        reset_dut();
        build_instr(32'h0020A023, 1'b0, 0, 0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            exp_t e = exp_q.pop_front();
            drive(e);
            n_cmp++;
            if (((obs ^ e.val) & e.care) !== '0) begin
                n_bad++; $display("FAIL swrst_%s: got %05h want %05h care %05h", e.tag, obs, e.val, e.care);
            end
            @(posedge clk); #1;
        end
        exp_q.delete();
        mem_ready = 1'b0; rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (mem_write !== 1'b1 || iord !== 1'b1) begin
            n_bad++; $display("FAIL swrst_mem_before: got wr %b iord %b want 1 1", mem_write, iord);
        end
        @(posedge clk); #1;
        rst = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (obs !== '0) begin
            n_bad++; $display("FAIL swrst_after: got %05h want 00000", obs);
        end
        if (mem_read === 1'b1) first = 0;
        @(posedge clk); #1;
        for (int i = 1; i < 12 && first < 0; i++) begin
            @(negedge clk);
            if (mem_read === 1'b1) first = i;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (first != 4) begin
            n_bad++; $display("FAIL swrst_first_fetch: got cycle %0d want 4", first);
        end
    endtask

    task automatic test_back_to_back();
        reset_dut();
        for (int n = 0; n < 60; n++) begin
            int k = $urandom_range(0, 6);
            int fw = $urandom_range(0, 3);
            int mw = (k == K_LW || k == K_SW) ? $urandom_range(0, 3) : 0;
            int idx = 0, ret_at = -1;
            logic [31:0] w = make_instr(k);
            build_instr(w, 1'($urandom_range(0, 1)), fw, mw, 1'b0);
            while (exp_q.size() > 0) begin
                exp_t e = exp_q.pop_front();
                idx++;
                drive(e);
                n_cmp++;
                if (((obs ^ e.val) & e.care) !== '0 || (mem_read & mem_write) !== 1'b0) begin
                    n_bad++; $display("FAIL rnd%0d_%08h_%s: got %05h want %05h care %05h", n, w, e.tag, obs, e.val, e.care);
                end
                if (retire === 1'b1 && ret_at < 0) ret_at = idx;
                @(posedge clk); #1;
            end
            n_cmp++;
            if (ret_at != base_cycles(k) + fw + mw) begin
                n_bad++; $display("FAIL rnd%0d_retire_cycle: got %0d want %0d", n, ret_at, base_cycles(k) + fw + mw);
            end
        end
    endtask

    initial begin
        rst = 1'b1; instr = '0; zero = 1'b0; mem_ready = 1'b0; cur_ir = '0;
        @(posedge clk); #1;
        test_reset();
        test_add();
        test_lw_wait();
        test_beq();
        test_jal();
        test_illegal();
        test_reset_mid_sw();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
